// File: rtl/reg_file_pkg.sv
// -----------------------------------------------------------------------------
// reg_file_pkg
//
// Shared constants and types for the 16x16 register file slice.
//
//   WIDTH   : data width of one register
//   ADDR_W  : register select width
//   DEPTH   : number of registers (2**ADDR_W)
//   state_e : clear sequencer state (IDLE / CLEAR)
// -----------------------------------------------------------------------------
package reg_file_pkg;

    localparam int WIDTH  = 16;
    localparam int ADDR_W = 4;
    localparam int DEPTH  = 1 << ADDR_W;

    // IDLE accepts writes; CLEAR walks the counter across R1..R(DEPTH-1).
    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_e;

endpackage : reg_file_pkg

// File: rtl/reg_clear_seq.sv
// -----------------------------------------------------------------------------
// reg_clear_seq
//
// Hardware clear sequencer for the register file. On a sampled clr in IDLE it
// enters CLEAR with the counter at 1 and, for each of the following DEPTH-1
// cycles, presents one register index to be zeroed. Register 0 is hardwired
// to zero, so it is never visited. clr is ignored while a sequence runs.
//
// Ports
//   clk        in   clock, rising edge
//   rst_n      in   asynchronous active-low reset (aborts a running sequence)
//   clr_i      in   start request, level sampled each cycle
//   idle_o     out  sequencer is in IDLE (writes may be accepted)
//   clr_en_o   out  register clr_idx_o is zeroed at the end of this cycle
//   clr_idx_o  out  index of the register being cleared this cycle
//   busy_o     out  registered busy flag, high for the whole CLEAR phase
// -----------------------------------------------------------------------------
module reg_clear_seq #(
    parameter int ADDR_W = reg_file_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr_i,
    output logic              idle_o,
    output logic              clr_en_o,
    output logic [ADDR_W-1:0] clr_idx_o,
    output logic              busy_o
);

    import reg_file_pkg::*;

    // Last register to clear: all-ones index.
    localparam logic [ADDR_W-1:0] LAST_IDX  = '1;
    localparam logic [ADDR_W-1:0] FIRST_IDX = ADDR_W'(1);

    state_e            state_q;
    logic [ADDR_W-1:0] cnt_q;
    logic              busy_q;

    // NOTE: sequential state is updated with non-blocking assignments only, so
    // every flop samples the pre-edge values of its neighbours.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (clr_i) begin
                        state_q <= CLEAR;
                        cnt_q   <= FIRST_IDX;
                        busy_q  <= 1'b1;
                    end
                end
                CLEAR: begin
                    // The final index is still cleared this cycle (clr_en_o is
                    // high); leaving CLEAR takes effect on the following edge.
                    if (cnt_q == LAST_IDX) begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                        busy_q  <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + FIRST_IDX;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign idle_o    = (state_q == IDLE);
    assign clr_en_o  = (state_q == CLEAR);
    assign clr_idx_o = cnt_q;
    assign busy_o    = busy_q;

endmodule : reg_clear_seq

// File: rtl/reg_file_16x16.sv
// -----------------------------------------------------------------------------
// reg_file_16x16
//
// 16-entry x 16-bit general-purpose register file: one write port, two
// combinational read ports with write-through bypass, and a hardware clear
// sequencer. Register 0 always reads zero and is never stored to.
//
// Ports
//   clk      in   clock, rising edge
//   rst_n    in   asynchronous active-low reset; zeroes all state
//   we       in   write request for this cycle
//   waddr    in   destination register
//   wdata    in   write-back data
//   raddr_a  in   operand A select
//   rdata_a  out  operand A data (combinational)
//   raddr_b  in   operand B select
//   rdata_b  out  operand B data (combinational)
//   clr      in   start clear sequence (level sampled)
//   busy     out  registered, high while the clear sequence runs
//   wr_ack   out  registered pulse: previous cycle's write was accepted
// -----------------------------------------------------------------------------
module reg_file_16x16 #(
    parameter int WIDTH  = reg_file_pkg::WIDTH,
    parameter int ADDR_W = reg_file_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic [ADDR_W-1:0] raddr_a,
    output logic [WIDTH-1:0]  rdata_a,
    input  logic [ADDR_W-1:0] raddr_b,
    output logic [WIDTH-1:0]  rdata_b,
    input  logic              clr,
    output logic              busy,
    output logic              wr_ack
);

    import reg_file_pkg::*;

    localparam int N_REGS = 1 << ADDR_W;

    // -------------------------------------------------------------------------
    // Clear sequencer
    // -------------------------------------------------------------------------
    logic              seq_idle;
    logic              seq_clr_en;
    logic [ADDR_W-1:0] seq_clr_idx;

    reg_clear_seq #(
        .ADDR_W (ADDR_W)
    ) u_clear_seq (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr_i     (clr),
        .idle_o    (seq_idle),
        .clr_en_o  (seq_clr_en),
        .clr_idx_o (seq_clr_idx),
        .busy_o    (busy)
    );

    // -------------------------------------------------------------------------
    // Write acceptance
    // -------------------------------------------------------------------------
    // A write is accepted only in IDLE with no clr in the same cycle; clr wins
    // and the write is silently dropped. Writes to R0 are accepted (and
    // acknowledged) but have no storage effect.
    logic wr_accept;
    logic wr_store;

    assign wr_accept = seq_idle && !clr && we;
    assign wr_store  = wr_accept && (waddr != '0);

    // -------------------------------------------------------------------------
    // Storage
    // -------------------------------------------------------------------------
    logic [WIDTH-1:0] regs_q [N_REGS];
    logic [WIDTH-1:0] regs_d [N_REGS];

    // NOTE: every variable driven here gets a full default first, so no path
    // through the block leaves a value unassigned and no latch is inferred.
    always_comb begin
        regs_d = regs_q;
        if (seq_clr_en) begin
            regs_d[seq_clr_idx] = '0;
        end
        // Clear and store are mutually exclusive (stores need IDLE), so the
        // ordering of these two updates never matters.
        if (wr_store) begin
            regs_d[waddr] = wdata;
        end
        regs_d[0] = '0;
    end

    // NOTE: the storage array is reset explicitly because an asynchronous
    // reset must leave every register reading zero without a clock edge; this
    // keeps it in flops rather than a RAM macro.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    // -------------------------------------------------------------------------
    // Write acknowledge
    // -------------------------------------------------------------------------
    logic wr_ack_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ack_q <= 1'b0;
        end else begin
            wr_ack_q <= wr_accept;
        end
    end

    assign wr_ack = wr_ack_q;

    // -------------------------------------------------------------------------
    // Read ports with write-through bypass
    // -------------------------------------------------------------------------
    // Bypass only forwards writes that will actually be stored, so R0 and
    // dropped writes (clr or CLEAR state) never leak onto the read ports.
    logic bypass_a;
    logic bypass_b;

    assign bypass_a = wr_store && (waddr == raddr_a);
    assign bypass_b = wr_store && (waddr == raddr_b);

    assign rdata_a = (raddr_a == '0) ? '0 :
                     bypass_a        ? wdata : regs_q[raddr_a];
    assign rdata_b = (raddr_b == '0) ? '0 :
                     bypass_b        ? wdata : regs_q[raddr_b];

endmodule : reg_file_16x16
